// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the UART: buffers CPU bytes in a TX FIFO, sequences the transmitter, holds RX bytes.
// Latency: bus read data one cycle after bus_re; DATA write to tx_send is 3 cycles with an idle transmitter.
// Backpressure: none on the bus; a DATA write into a full FIFO is dropped and flagged in tx_drop.
module uart_mmio_ctrl #(
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int          AW        = $clog2(TX_DEPTH);
  localparam int          PW        = AW + 1;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAITB,
    ST_WAITD
  } state_t;

  state_t      state_q;
  logic        tx_send_q;
  logic [7:0]  tx_data_q;
  logic [1:0]  wait_cnt_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [TX_DEPTH];

  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        rx_full_q, rx_full_d;
  logic        overrun_q, overrun_d;
  logic        tx_drop_q, tx_drop_d;
  logic [31:0] rdata_q, rdata_d;

  // Address decode; the two low address bits never take part.
  logic sel_data, sel_stat;
  logic data_wr, stat_wr, data_rd, stat_rd;
  assign sel_data = (bus_addr[31:2] == BASE_ADDR[31:2]);
  assign sel_stat = (bus_addr[31:2] == STAT_ADDR[31:2]);
  // A simultaneous write and read is handled purely as a write.
  assign data_wr  = bus_we & sel_data;
  assign stat_wr  = bus_we & sel_stat;
  assign data_rd  = bus_re & ~bus_we & sel_data;
  assign stat_rd  = bus_re & ~bus_we & sel_stat;

  // FIFO flags from the extra pointer MSB.
  logic fifo_full, fifo_empty, fifo_pop, fifo_push, fifo_drop;
  logic [7:0] fifo_head;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
  // The head leaves the FIFO in LOAD; LOAD is only entered when non-empty.
  assign fifo_pop   = (state_q == ST_LOAD);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign fifo_push  = data_wr & (~fifo_full | fifo_pop);
  assign fifo_drop  = data_wr & fifo_full & ~fifo_pop;

  logic tx_active;
  assign tx_active = (state_q != ST_IDLE);

  // Status map: 5 tx_drop, 4 tx_active, 3 overrun, 2 rx_full, 1 tx_empty, 0 tx_full.
  logic [31:0] status;
  assign status = {26'b0, tx_drop_q, tx_active, overrun_q, rx_full_q, fifo_empty, fifo_full};

  // Next-state for pointers, RX holding register, sticky flags and read data.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    overrun_d = overrun_q;
    tx_drop_d = tx_drop_q;
    rdata_d   = 32'b0;

    if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (stat_wr && bus_wdata[5]) tx_drop_d = 1'b0;
    if (fifo_drop)               tx_drop_d = 1'b1;

    // A DATA read in the same cycle as a new byte consumes the old one, so no overrun.
    if (stat_wr && bus_wdata[3])                  overrun_d = 1'b0;
    if (rx_valid && rx_full_q && !data_rd)        overrun_d = 1'b1;

    if (data_rd)  rx_full_d = 1'b0;
    if (rx_valid) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end

    if (data_rd)      rdata_d = {24'b0, rx_hold_q};
    else if (stat_rd) rdata_d = status;
  end

  // Register bank for the datapath state computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
      overrun_q <= 1'b0;
      tx_drop_q <= 1'b0;
      rdata_q   <= 32'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
      overrun_q <= overrun_d;
      tx_drop_q <= tx_drop_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= bus_wdata[7:0];
  end

  // Transmit sequencer with registered tx_send / tx_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      wait_cnt_q <= 2'd0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !tx_busy) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_q <= fifo_head;
          tx_send_q <= 1'b1;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          wait_cnt_q <= 2'd0;
          state_q    <= ST_WAITB;
        end
        ST_WAITB: begin
          // A transmitter that never raises busy is assumed done after 4 quiet cycles.
          if (tx_busy)                  state_q    <= ST_WAITD;
          else if (wait_cnt_q == 2'd3)  state_q    <= ST_IDLE;
          else                          wait_cnt_q <= wait_cnt_q + 2'd1;
        end
        ST_WAITD: begin
          if (!tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_rdata = rdata_q;
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: drivers push expected reads and TX bytes,
// a monitor pops and compares when read data or a tx_send pulse appears.
// Inputs change on the falling edge; outputs are sampled 2 ns after the rising edge.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_addr = 32'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  uart_mmio_ctrl #(.TX_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         cyc;   // -1: timing not checked
  } tx_exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          sends_seen = 0;
  logic [31:0] exp_rd[$];
  string       rd_name[$];
  tx_exp_t     exp_tx[$];
  logic        busy_hold = 1'b0;
  int          busy_mode = 0;   // 0: 10-cycle busy after each send, 1: never busy

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares read data and every tx_send pulse against the queues.
  initial begin
    forever begin
      logic    rd_at_edge;
      tx_exp_t e;
      @(posedge clk);
      cyc++;
      rd_at_edge = bus_re && !bus_we && !rst;
      #2;
      if (rd_at_edge) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_read", bus_rdata, 32'hDEAD_BEEF);
        end else begin
          check(rd_name.pop_front(), bus_rdata, exp_rd.pop_front());
        end
      end
      if (tx_send === 1'b1) begin
        sends_seen++;
        if (exp_tx.size() == 0) begin
          check("unexpected_tx_send", {24'b0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'b0, tx_data}, {24'b0, e.b});
          if (e.cyc >= 0) check("tx_send_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Transmitter model: busy follows each send for 10 cycles unless disabled or forced.
  initial begin
    int cnt = 0;
    int last_sends = 0;
    forever begin
      @(negedge clk);
      if (sends_seen != last_sends) begin
        last_sends = sends_seen;
        if (busy_mode == 0) cnt = 10;
      end
      tx_busy = busy_hold || (cnt > 0);
      if (cnt > 0) cnt--;
    end
  end

  // All drivers are entered on a falling edge and return on a falling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_rd.push_back(exp);
    rd_name.push_back(name);
    bus_addr = addr;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_done(input int limit, input string name);
    int n = 0;
    while (exp_tx.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_tx.size() != 0) begin
      failures++;
      $display("FAIL %s: timeout, %0d bytes still expected, required 0", name, exp_tx.size());
      exp_tx.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Asynchronous reset asserted between clock edges.
    #3 rst = 1'b1;
    #1;
    check("reset_rdata",   bus_rdata,          32'h0);
    check("reset_tx_send", {31'b0, tx_send},   32'h0);
    check("reset_tx_data", {24'b0, tx_data},   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    bus_read(32'h4, 32'h02, "status_after_reset");

    // 2. Single byte, 3-cycle latency, tx_active while the transmitter is busy.
    busy_mode = 0;
    exp_tx.push_back('{b: 8'h41, cyc: cyc + 3});
    bus_write(32'h0, 32'h41);
    idle(4);
    bus_read(32'h4, 32'h12, "status_busy");
    idle(15);
    bus_read(32'h4, 32'h02, "status_done");

    // 3. Overfill the FIFO while the transmitter is held busy.
    busy_hold = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) bus_write(32'h0, 32'h30 + i);
    bus_read(32'h4, 32'h21, "status_full_drop");
    for (int i = 0; i < 4; i++) exp_tx.push_back('{b: 8'(8'h30 + i), cyc: -1});
    busy_hold = 1'b0;
    wait_tx_done(300, "fifo_drain");
    idle(20);
    bus_read(32'h4, 32'h22, "status_drop_sticky");
    bus_write(32'h4, 32'h20);
    bus_read(32'h4, 32'h02, "status_drop_cleared");

    // 4. Overrun on two unread bytes.
    rx_pulse(8'h5A);
    rx_pulse(8'h5B);
    bus_read(32'h4, 32'h0E, "status_overrun");
    bus_read(32'h0, 32'h5B, "data_overrun_byte");
    bus_read(32'h4, 32'h0A, "status_after_data_read");
    bus_write(32'h4, 32'h08);
    bus_read(32'h4, 32'h02, "status_overrun_cleared");

    // 5. New byte arriving in the same cycle as a DATA read.
    rx_pulse(8'h11);
    exp_rd.push_back(32'h11);
    rd_name.push_back("data_coincident_read");
    bus_addr = 32'h0;
    bus_re   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    @(negedge clk);
    bus_re   = 1'b0;
    rx_valid = 1'b0;
    bus_read(32'h4, 32'h06, "status_coincident");
    bus_read(32'h0, 32'h22, "data_second_byte");
    bus_read(32'h4, 32'h02, "status_rx_empty");

    // 6. Transmitter never raises busy: 4-cycle timeout, then next byte.
    busy_mode = 1;
    exp_tx.push_back('{b: 8'h77, cyc: cyc + 3});
    exp_tx.push_back('{b: 8'h78, cyc: cyc + 10});
    bus_write(32'h0, 32'h77);
    bus_write(32'h0, 32'hFFFF_FF78);
    wait_tx_done(100, "busy_timeout_drain");
    idle(10);
    bus_read(32'h4, 32'h02, "status_after_timeout");

    // Unmapped address: write ignored, read returns 0.
    bus_write(32'h8, 32'h55);
    bus_read(32'h8, 32'h0, "unmapped_read");

    // Write and read strobes together act as a write only.
    rx_pulse(8'h33);
    exp_tx.push_back('{b: 8'hAB, cyc: -1});
    bus_addr  = 32'h0;
    bus_wdata = 32'h0000_01AB;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    wait_tx_done(100, "we_re_write");
    idle(10);
    bus_read(32'h7, 32'h06, "status_low_addr_bits");
    bus_read(32'h0, 32'h33, "data_after_we_re");
    bus_read(32'h4, 32'h02, "status_final");

    idle(5);
    check("rd_queue_drained", exp_rd.size(), 32'h0);
    check("tx_queue_drained", exp_tx.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
